// File: rtl/sync_pulse_multich_if.sv
// Event-line bundle for sync_pulse_multich.
// master drives the raw levels and clears; slave is the synchronizer.
interface sync_pulse_multich_if #(
  parameter int CH = 4
);
  logic [CH-1:0] signal_in;
  logic [CH-1:0] overrun_clr;
  logic [CH-1:0] sync_out;
  logic [CH-1:0] pulse_out;
  logic [CH-1:0] overrun;

  modport master (
    output signal_in,
    output overrun_clr,
    input  sync_out,
    input  pulse_out,
    input  overrun
  );

  modport slave (
    input  signal_in,
    input  overrun_clr,
    output sync_out,
    output pulse_out,
    output overrun
  );
endinterface

// File: rtl/sync_pulse_multich.sv
// Multi-channel level synchronizer with edge-to-pulse stretching
// and a sticky per-channel overrun flag.
module sync_pulse_multich #(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 0,
  parameter int PULSE_LEN   = 1,
  localparam int CW         = $clog2(PULSE_LEN + 1)
) (
  input logic                 clk,
  input logic                 rst,
  sync_pulse_multich_if.slave bus
);

  if (CH < 1 || CH > 32 ||
      SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
      EDGE_MODE < 0 || EDGE_MODE > 2 ||
      PULSE_LEN < 1 || PULSE_LEN > 255) begin : g_bad_param
    $error("sync_pulse_multich: parameter out of range");
  end

  localparam logic [CW-1:0] LOAD = CW'(PULSE_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q [CH];
  logic [SYNC_STAGES-1:0] sync_d [CH];
  logic [CW-1:0]          cnt_q  [CH];
  logic [CW-1:0]          cnt_d  [CH];

  logic [CH-1:0] prev_q;
  logic [CH-1:0] pulse_q;
  logic [CH-1:0] pulse_d;
  logic [CH-1:0] ovr_q;
  logic [CH-1:0] ovr_d;
  logic [CH-1:0] last;
  logic [CH-1:0] rise;
  logic [CH-1:0] fall;
  logic [CH-1:0] edg;

  always_comb begin
    for (int i = 0; i < CH; i++) begin
      sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], bus.signal_in[i]};
      last[i]   = sync_q[i][SYNC_STAGES-1];
    end
  end

  assign rise = last & ~prev_q;
  assign fall = ~last & prev_q;

  always_comb begin
    edg = rise | fall;
    if (EDGE_MODE == 0) edg = rise;
    if (EDGE_MODE == 1) edg = fall;
  end

  // Any edge reloads the counter, so an active pulse is extended.
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      cnt_d[i]   = cnt_q[i];
      pulse_d[i] = 1'b0;
      if (edg[i]) begin
        cnt_d[i]   = LOAD;
        pulse_d[i] = 1'b1;
      end else if (cnt_q[i] != '0) begin
        cnt_d[i]   = cnt_q[i] - CW'(1);
        pulse_d[i] = 1'b1;
      end
    end
  end

  assign ovr_d = (edg & pulse_q) | (ovr_q & ~bus.overrun_clr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CH; i++) begin
        sync_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      prev_q  <= '0;
      pulse_q <= '0;
      ovr_q   <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        sync_q[i] <= sync_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      prev_q  <= last;
      pulse_q <= pulse_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.sync_out  = last;
  assign bus.pulse_out = pulse_q;
  assign bus.overrun   = ovr_q;

endmodule

// File: tb/tb_sync_pulse_multich.sv
// Scoreboard bench: four configurations share one stimulus stream
// and are checked against a window-based model of the pulse rules.
module tb_sync_pulse_multich;

  localparam int S = 2;
  localparam int NI = 4;
  localparam int MODE [NI] = '{0, 2, 1, 0};
  localparam int LEN  [NI] = '{3, 3, 3, 1};

  typedef struct packed {
    logic            rnd;
    logic [3:0][3:0] so;
    logic [3:0][3:0] po;
    logic [3:0][3:0] ov;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sig;
  logic [3:0] clr;
  logic       rnd = 1'b0;

  logic [3:0] so [NI];
  logic [3:0] po [NI];
  logic [3:0] ov [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : u
    sync_pulse_multich_if #(.CH(4)) b ();
    assign b.signal_in   = sig;
    assign b.overrun_clr = clr;
    assign so[g] = b.sync_out;
    assign po[g] = b.pulse_out;
    assign ov[g] = b.overrun;
    sync_pulse_multich #(
      .CH(4),
      .SYNC_STAGES(S),
      .EDGE_MODE(MODE[g]),
      .PULSE_LEN(LEN[g])
    ) dut (
      .clk(clk),
      .rst(rst),
      .bus(b.slave)
    );
  end

  int n_pass = 0;
  int n_tot  = 0;
  int edges_m = 0;
  int pulses_d = 0;

  task automatic chk(string nm, int inst, logic [3:0] act, logic [3:0] want);
    n_tot++;
    if (act === want) n_pass++;
    else $display("FAIL %s inst%0d: got %b want %b at %0t",
                  nm, inst, act, want, $time);
  endtask

  // Model: s_h[k] is the level captured at the k-th edge after reset.
  logic [3:0] s_h [0:4095];
  int         k = 0;
  logic [3:0] ovm [NI];
  exp_t       q [$];

  function automatic logic [3:0] lv(int j);
    return (j < 1) ? 4'b0 : s_h[j];
  endfunction

  // Edge seen by the detector in the cycle that follows edge j.
  function automatic logic [3:0] det(int mode, int j);
    logic [3:0] a, b;
    a = lv(j - S + 1);
    b = lv(j - S);
    if (mode == 0) return a & ~b;
    if (mode == 1) return ~a & b;
    return a ^ b;
  endfunction

  // Pulse after edge m: some selected edge within the last len cycles.
  function automatic logic [3:0] pls(int mode, int len, int m);
    logic [3:0] r = 4'b0;
    for (int j = m - len; j < m; j++) r |= det(mode, j);
    return r;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    if (rst) begin
      k = 0;
      for (int i = 0; i < NI; i++) ovm[i] = 4'b0;
    end else begin
      k++;
      s_h[k] = sig;
      e.rnd = rnd;
      for (int i = 0; i < NI; i++) begin
        e.so[i] = lv(k - S + 1);
        e.po[i] = pls(MODE[i], LEN[i], k);
        ovm[i] = (det(MODE[i], k - 1) & pls(MODE[i], LEN[i], k - 1))
               | (ovm[i] & ~clr);
        e.ov[i] = ovm[i];
      end
      if (rnd) edges_m += $countones(det(MODE[3], k - 1));
      q.push_back(e);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) q.delete();
    else if (q.size() != 0) begin
      e = q.pop_front();
      for (int i = 0; i < NI; i++) begin
        chk("sync_out", i, so[i], e.so[i]);
        chk("pulse_out", i, po[i], e.po[i]);
        chk("overrun", i, ov[i], e.ov[i]);
      end
      if (e.rnd) pulses_d += $countones(po[3]);
    end
  end

  initial begin
    #1ms;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int hold [4];
    sig = 4'b0;
    clr = 4'b0;
    rst = 1'b1;
    cyc(3);
    for (int i = 0; i < NI; i++) begin
      chk("rst_sync", i, so[i], 4'b0);
      chk("rst_pulse", i, po[i], 4'b0);
      chk("rst_ovr", i, ov[i], 4'b0);
    end
    rst = 1'b0;
    cyc(3);

    sig[0] = 1'b1;
    cyc(10);

    sig[1] = 1'b1;
    cyc(2);
    sig[1] = 1'b0;
    cyc(8);
    clr = 4'b0010;
    cyc(1);
    clr = 4'b0;
    cyc(3);

    sig[1] = 1'b1;
    cyc(2);
    sig[1] = 1'b0;
    cyc(2);
    sig[1] = 1'b1;
    clr = 4'b0010;
    cyc(4);
    clr = 4'b0;
    cyc(6);

    sig[2] = 1'b1;
    cyc(6);
    sig[2] = 1'b0;
    cyc(6);

    sig = 4'b0;
    cyc(6);
    sig = 4'b1111;
    cyc(6);

    sig = 4'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("pre_rst_pulse", 2, po[2], 4'b1111);
    rst = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("async_rst_pulse", i, po[i], 4'b0);
      chk("async_rst_ovr", i, ov[i], 4'b0);
    end
    cyc(2);
    rst = 1'b0;
    cyc(4);

    rnd = 1'b1;
    for (int c = 0; c < 4; c++) hold[c] = 3;
    repeat (300) begin
      @(negedge clk);
      for (int c = 0; c < 4; c++) begin
        hold[c]++;
        if (hold[c] >= 3 && $urandom_range(0, 3) == 0) begin
          sig[c] = ~sig[c];
          hold[c] = 0;
        end
        clr[c] = ($urandom_range(0, 7) == 0);
      end
    end
    clr = 4'b0;
    cyc(6);
    rnd = 1'b0;
    cyc(1);
    #1;
    n_tot++;
    if (pulses_d == edges_m && edges_m > 0) n_pass++;
    else $display("FAIL pulse_count: got %0d want %0d", pulses_d, edges_m);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
